or_stim_gen: RTL



---
 rtl/or_stim_pkg.sv | 14 +
 rtl/or_stim_dwell_ctr.sv | 38 +++
 rtl/or_stim_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/or_stim_pkg.sv
// Shared encodings for the OR-block stimulus sequencer.
package or_stim_pkg;

   // Sequencer states; values are fixed so external debug views stay stable.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } or_stim_state_e;

   // One full sweep of the four OR inputs.
   localparam int unsigned NUM_PATTERNS = 16;

endpackage

// File: rtl/or_stim_dwell_ctr.sv
// Modulo-DWELL counter; tc_o marks the last cycle a pattern is held.
module or_stim_dwell_ctr #(
   parameter int unsigned DWELL = 50
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CntW = $clog2(DWELL);
   localparam logic [CntW-1:0] LastCnt = CntW'(DWELL - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == LastCnt);

   // Next count: clear wins over enable; wrap to zero after the last dwell cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/or_stim_gen.sv
// Stimulus sequencer for the four-input OR block: binary sweep of a/b/c/d with
// programmable dwell and pass count, start/done handshake and sample strobe.
module or_stim_gen
   import or_stim_pkg::*;
#(
   parameter int unsigned DWELL      = 50,
   parameter int unsigned NUM_PASSES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic [3:0] pattern_idx,
   output logic       sample,
   output logic       busy,
   output logic       done
);

   if (DWELL < 2) begin : g_bad_dwell
      $error("or_stim_gen: DWELL must be >= 2");
   end
   if (NUM_PASSES < 1) begin : g_bad_passes
      $error("or_stim_gen: NUM_PASSES must be >= 1");
   end

   localparam int unsigned PassW = $clog2(NUM_PASSES + 1);
   localparam logic [3:0] LastPattern = 4'(NUM_PATTERNS - 1);
   localparam logic [PassW-1:0] PassLimit = PassW'(NUM_PASSES);

   or_stim_state_e   state_q, state_d;
   logic [3:0]       pattern_q, pattern_d;
   logic [PassW-1:0] pass_q, pass_d;
   logic             tc;

   // Counter only runs in RUN; an abort clears it so a restart begins a fresh dwell.
   or_stim_dwell_ctr #(
      .DWELL (DWELL)
   ) u_dwell_ctr (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .clr_i  ((state_q != ST_RUN) | abort),
      .en_i   (state_q == ST_RUN),
      .tc_o   (tc)
   );

   // State, pattern and pass registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         pass_q    <= '0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         pass_q    <= pass_d;
      end
   end

   // Next-state: start from IDLE, step patterns on dwell terminal count, abort to IDLE.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      pass_d    = pass_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               pattern_d = '0;
               pass_d    = '0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d   = ST_IDLE;
               pattern_d = '0;
               pass_d    = '0;
            end else if (tc) begin
               // 15 -> 0 wrap is the natural 4-bit overflow; no gap between passes.
               pattern_d = pattern_q + 4'd1;
               if (pattern_q == LastPattern) begin
                  pass_d = pass_q + PassW'(1);
                  if (pass_d == PassLimit) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            pass_d  = '0;
         end
         default: begin
            state_d   = ST_IDLE;
            pattern_d = '0;
            pass_d    = '0;
         end
      endcase
   end

   // Outputs decoded from registers; abort masks a coincident sample in the same cycle.
   always_comb begin
      {a, b, c, d} = pattern_q;
      pattern_idx  = pattern_q;
      busy         = (state_q == ST_RUN);
      done         = (state_q == ST_DONE);
      sample       = (state_q == ST_RUN) & tc & ~abort;
   end

endmodule
